i2lbs_scan_ctrl: RTL

Parametrised window-scan controller for the integral-image / LBS classification path. It replaces the fixed three-state request/receive/inspect sequencer with a registered FSM in the `clk_fpga` domain. The FSM derives window anchors from the resized-coordinate stream using a configurable stride and queues one pending anchor. It hands out pixel requests and inspect starts, then returns candidate window coordinates over a valid/ready handshake. It sits between the resize stage, the integral-image memory and the classifier bank.

---
 rtl/i2lbs_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2lbs_scan_ctrl.sv
// ---------------------------------------------------------------------------
// i2lbs_scan_ctrl
//
// Window-scan controller for the integral-image / LBS classification path.
// Watches the resized pixel stream, derives window anchors (top-left corners)
// on a STEP grid, and sequences each window through
// request -> receive -> inspect -> (optional) candidate report.
// One anchor may be queued while a window is in flight; later ones are dropped
// and counted.
//
// Optional feature: define I2LBS_INSPECT_TIMEOUT_EN to add an inspect
// watchdog (TIMEOUT_CYCLES). Without it INSPECT waits indefinitely and
// o_timeout is tied low.
//
// Ports
//   clk_fpga, reset_fpga        : clock, synchronous active-high reset
//   i_pixel_valid, i_resize_x/y : resized pixel stream (raster order)
//   o_pixel_request             : window pixel request to memory (REQUEST)
//   i_pixel_recieve             : memory acknowledge (may be a pulse)
//   i_integral_image_ready      : integral window valid
//   o_inspect_start             : one-cycle classifier start
//   i_inspect_done, i_candidate : classifier finish pulse and verdict
//   o_candidate_valid/_x/_y     : candidate window, held until i_candidate_ready
//   o_busy                      : FSM active or anchor pending
//   o_frame_done                : one-cycle end-of-frame pulse
//   o_drop_count                : saturating count of discarded anchors
//   o_timeout                   : one-cycle watchdog pulse (macro only)
// ---------------------------------------------------------------------------
module i2lbs_scan_ctrl #(
    parameter int DATA_WIDTH_12              = 12,
    parameter int INTEGRAL_WIDTH             = 3,
    parameter int INTEGRAL_HEIGHT            = 3,
    parameter int FRAME_RESIZE_CAMERA_WIDTH  = 10,
    parameter int FRAME_RESIZE_CAMERA_HEIGHT = 10,
    parameter int STEP                       = 1,
    parameter int TIMEOUT_CYCLES             = 1024
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_pixel_valid,
    input  logic [DATA_WIDTH_12-1:0] i_resize_x,
    input  logic [DATA_WIDTH_12-1:0] i_resize_y,
    output logic                     o_pixel_request,
    input  logic                     i_pixel_recieve,
    input  logic                     i_integral_image_ready,
    output logic                     o_inspect_start,
    input  logic                     i_inspect_done,
    input  logic                     i_candidate,
    output logic                     o_candidate_valid,
    input  logic                     i_candidate_ready,
    output logic [DATA_WIDTH_12-1:0] o_candidate_x,
    output logic [DATA_WIDTH_12-1:0] o_candidate_y,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic [7:0]               o_drop_count,
    output logic                     o_timeout
);

    localparam int DW = DATA_WIDTH_12;
    localparam int PW = (STEP > 1) ? $clog2(STEP) : 1;

    localparam logic [DW-1:0] WIN_X0  = DW'(INTEGRAL_WIDTH - 1);
    localparam logic [DW-1:0] WIN_Y0  = DW'(INTEGRAL_HEIGHT - 1);
    localparam logic [DW-1:0] FR_XMAX = DW'(FRAME_RESIZE_CAMERA_WIDTH - 1);
    localparam logic [DW-1:0] FR_YMAX = DW'(FRAME_RESIZE_CAMERA_HEIGHT - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_INSPECT = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0] x_ph_q, y_ph_q;
    logic [PW-1:0] x_ph, y_ph_row, y_ph;

    logic          anchor_hit, eof_hit, to_pending;
    logic [DW-1:0] anchor_x, anchor_y;

    logic          pend_v_q;
    logic [DW-1:0] pend_x_q, pend_y_q;
    logic [DW-1:0] cur_x_q, cur_y_q;
    logic          sticky_q, sticky_d;
    logic          start_q, start_d;
    logic          take_live, take_pend;
    logic          eof_q, frame_done;
    logic [7:0]    drop_q;

    // -----------------------------------------------------------------------
    // Stride phase tracking. The stream is raster ordered, so the phase of a
    // column restarts at x == W-1 and advances by one per accepted pixel; the
    // row phase restarts at y == H-1 and advances at the first pixel (x == 0)
    // of each row. Phase 0 in both axes marks a grid point.
    // -----------------------------------------------------------------------
    always_comb begin
        x_ph     = '0;
        y_ph_row = '0;
        if (i_resize_x != WIN_X0 && x_ph_q != PH_LAST)
            x_ph = x_ph_q + PW'(1);
        if (i_resize_y != WIN_Y0 && y_ph_q != PH_LAST)
            y_ph_row = y_ph_q + PW'(1);
        y_ph = (i_resize_x == '0) ? y_ph_row : y_ph_q;
    end

    assign anchor_hit = i_pixel_valid &&
                        (i_resize_x <= FR_XMAX) && (i_resize_y <= FR_YMAX) &&
                        (i_resize_x >= WIN_X0)  && (i_resize_y >= WIN_Y0)  &&
                        (x_ph == '0) && (y_ph == '0);
    assign anchor_x   = i_resize_x - WIN_X0;
    assign anchor_y   = i_resize_y - WIN_Y0;
    assign eof_hit    = i_pixel_valid && (i_resize_x == FR_XMAX) &&
                        (i_resize_y == FR_YMAX);

    // Anchors seen while a window is in flight (including the cycle REPORT
    // is left) go to the pending slot.
    assign to_pending = anchor_hit && (state_q != ST_IDLE);

`ifdef I2LBS_INSPECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q;
    logic          timeout_q, timeout_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sticky_d  = sticky_q;
        start_d   = 1'b0;
        take_live = 1'b0;
        take_pend = 1'b0;
`ifdef I2LBS_INSPECT_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Live anchor wins; pending is only drained on a quiet cycle.
                if (anchor_hit) begin
                    state_d   = ST_REQUEST;
                    take_live = 1'b1;
                end else if (pend_v_q) begin
                    state_d   = ST_REQUEST;
                    take_pend = 1'b1;
                end
            end
            ST_REQUEST: begin
                if ((sticky_q || i_pixel_recieve) && i_integral_image_ready) begin
                    state_d  = ST_INSPECT;
                    start_d  = 1'b1;
                    sticky_d = 1'b0;
                end else if (i_pixel_recieve) begin
                    sticky_d = 1'b1;
                end
            end
            ST_INSPECT: begin
                if (i_inspect_done) begin
                    state_d = i_candidate ? ST_REPORT : ST_IDLE;
                end
`ifdef I2LBS_INSPECT_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            ST_REPORT: begin
                if (i_candidate_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign frame_done = eof_q && (state_q == ST_IDLE) && !pend_v_q;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state_q  <= ST_IDLE;
            sticky_q <= 1'b0;
            start_q  <= 1'b0;
            x_ph_q   <= '0;
            y_ph_q   <= '0;
            pend_v_q <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            eof_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            start_q  <= start_d;

            if (i_pixel_valid) begin
                x_ph_q <= x_ph;
                y_ph_q <= y_ph;
            end

            if (take_live) begin
                cur_x_q <= anchor_x;
                cur_y_q <= anchor_y;
            end else if (take_pend) begin
                cur_x_q <= pend_x_q;
                cur_y_q <= pend_y_q;
            end

            if (to_pending && !pend_v_q) begin
                pend_v_q <= 1'b1;
                pend_x_q <= anchor_x;
                pend_y_q <= anchor_y;
            end else if (to_pending) begin
                if (drop_q != 8'hFF)
                    drop_q <= drop_q + 8'd1;
            end else if (take_pend) begin
                pend_v_q <= 1'b0;
            end

            // A new end-of-frame pixel outranks clearing the old flag.
            if (eof_hit)
                eof_q <= 1'b1;
            else if (frame_done)
                eof_q <= 1'b0;
        end
    end

`ifdef I2LBS_INSPECT_TIMEOUT_EN
    // Counts cycles spent in INSPECT; restarts on every entry.
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if (state_q == ST_INSPECT && state_d == ST_INSPECT)
                to_cnt_q <= to_cnt_q + TW'(1);
            else
                to_cnt_q <= '0;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_pixel_request   = (state_q == ST_REQUEST);
    assign o_inspect_start   = start_q;
    assign o_candidate_valid = (state_q == ST_REPORT);
    assign o_candidate_x     = cur_x_q;
    assign o_candidate_y     = cur_y_q;
    assign o_busy            = (state_q != ST_IDLE) || pend_v_q;
    assign o_frame_done      = frame_done;
    assign o_drop_count      = drop_q;

endmodule
